// File: rtl/fpu_double_pkg.sv
// Shared binary64 constants, FSM encoding and unpacked-operand type for the double FPU blocks.
package fpu_double_pkg;

  localparam int unsigned WORD_W = 64;
  localparam int unsigned EXP_W  = 13;
  localparam int unsigned MAN_W  = 53;
  localparam int unsigned QUOT_W = 56;
  localparam int unsigned REM_W  = 54;
  localparam int unsigned CNT_W  = 6;

  localparam logic signed [EXP_W-1:0] BIAS         = 13'sd1023;
  localparam logic signed [EXP_W-1:0] EXP_MAX      = 13'sd1024;
  localparam logic signed [EXP_W-1:0] EXP_MIN_NORM = -13'sd1022;
  localparam logic signed [EXP_W-1:0] EXP_DENORM   = -13'sd1023;
  localparam int unsigned             INF_EXP      = 2047;

  localparam logic [WORD_W-1:0] CANON_NAN    = 64'hFFF8_0000_0000_0000;
  localparam logic [MAN_W-1:0]  MAN_ALL_ONES = {MAN_W{1'b1}};
  localparam logic [MAN_W-1:0]  MAN_HIDDEN   = MAN_W'(1) << (MAN_W - 1);

  typedef enum logic [3:0] {
    ST_GET_A,
    ST_GET_B,
    ST_UNPACK,
    ST_SPECIAL_CASES,
    ST_NORMALISE_A,
    ST_NORMALISE_B,
    ST_DIVIDE_0,
    ST_DIVIDE_1,
    ST_DIVIDE_2,
    ST_NORMALISE_1,
    ST_NORMALISE_2,
    ST_ROUND,
    ST_PACK,
    ST_PUT_Z
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } unpacked_t;

  function automatic logic [WORD_W-1:0] signed_inf(input logic s);
    return {s, 11'(INF_EXP), 52'd0};
  endfunction

  function automatic logic [WORD_W-1:0] signed_zero(input logic s);
    return {s, 63'd0};
  endfunction

endpackage

// File: rtl/double_round_pack.sv
// Combinational post-processing steps: one underflow shift, round-to-nearest-even and binary64 packing.
module double_round_pack
  import fpu_double_pkg::*;
(
  input  unpacked_t         z_i,
  input  logic              guard_i,
  input  logic              round_bit_i,
  input  logic              sticky_i,
  output logic              need_shift_c,
  output unpacked_t         shifted_c,
  output logic              shifted_guard_c,
  output logic              shifted_round_bit_c,
  output logic              shifted_sticky_c,
  output unpacked_t         rounded_c,
  output logic [WORD_W-1:0] packed_c
);

  logic round_up;

  always_comb begin
    need_shift_c        = $signed(z_i.exp) < EXP_MIN_NORM;
    shifted_c           = z_i;
    shifted_c.exp       = z_i.exp + EXP_W'(1);
    shifted_c.man       = z_i.man >> 1;
    shifted_guard_c     = z_i.man[0];
    shifted_round_bit_c = guard_i;
    shifted_sticky_c    = sticky_i | round_bit_i;

    // Ties go to the even mantissa; a carry out of the all-ones mantissa bumps the exponent.
    round_up  = guard_i && (round_bit_i || sticky_i || z_i.man[0]);
    rounded_c = z_i;
    if (round_up) begin
      if (z_i.man == MAN_ALL_ONES) begin
        rounded_c.man = MAN_HIDDEN;
        rounded_c.exp = z_i.exp + EXP_W'(1);
      end else begin
        rounded_c.man = z_i.man + MAN_W'(1);
      end
    end

    packed_c = {z_i.sign, 11'(z_i.exp + BIAS), z_i.man[51:0]};
    if ((z_i.exp == EXP_MIN_NORM) && !z_i.man[52]) begin
      packed_c[62:52] = '0;
    end
    if ($signed(z_i.exp) >= EXP_MAX) begin
      packed_c = signed_inf(z_i.sign);
    end
  end

endmodule

// File: rtl/double_divider.sv
// Binary64 divider z = a / b: stb/ack operand channels, restoring division at one quotient bit per clock.
module double_divider
  import fpu_double_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] input_a,
  input  logic              input_a_stb,
  output logic              input_a_ack,
  input  logic [WORD_W-1:0] input_b,
  input  logic              input_b_stb,
  output logic              input_b_ack,
  output logic [WORD_W-1:0] output_z,
  output logic              output_z_stb,
  input  logic              output_z_ack
);

  state_t            state_q, state_d;
  logic [WORD_W-1:0] in_a_q, in_a_d, in_b_q, in_b_d;
  unpacked_t         a_q, a_d, b_q, b_d, z_q, z_d;
  logic              guard_q, guard_d, round_bit_q, round_bit_d, sticky_q, sticky_d;
  logic [QUOT_W-1:0] quot_q, quot_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WORD_W-1:0] z_out_q, z_out_d;
  logic              a_ack_q, a_ack_d, b_ack_q, b_ack_d, z_stb_q, z_stb_d;

  logic              rp_need_shift, rp_guard, rp_round_bit, rp_sticky;
  unpacked_t         rp_shifted, rp_rounded;
  logic [WORD_W-1:0] rp_packed;

  logic             z_sign, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, rem_ge;
  logic [REM_W-1:0] rem_next;

  assign z_sign   = a_q.sign ^ b_q.sign;
  assign a_nan    = (a_q.exp == EXP_MAX) && (a_q.man != '0);
  assign b_nan    = (b_q.exp == EXP_MAX) && (b_q.man != '0);
  assign a_inf    = (a_q.exp == EXP_MAX) && (a_q.man == '0);
  assign b_inf    = (b_q.exp == EXP_MAX) && (b_q.man == '0);
  assign a_zero   = (a_q.exp == EXP_DENORM) && (a_q.man == '0);
  assign b_zero   = (b_q.exp == EXP_DENORM) && (b_q.man == '0);
  assign rem_ge   = rem_q >= REM_W'(b_q.man);
  assign rem_next = rem_ge ? (rem_q - REM_W'(b_q.man)) : rem_q;

  double_round_pack u_round_pack (
    .z_i                 (z_q),
    .guard_i             (guard_q),
    .round_bit_i         (round_bit_q),
    .sticky_i            (sticky_q),
    .need_shift_c        (rp_need_shift),
    .shifted_c           (rp_shifted),
    .shifted_guard_c     (rp_guard),
    .shifted_round_bit_c (rp_round_bit),
    .shifted_sticky_c    (rp_sticky),
    .rounded_c           (rp_rounded),
    .packed_c            (rp_packed)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_GET_A;
      in_a_q      <= '0;
      in_b_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      z_q         <= '0;
      guard_q     <= 1'b0;
      round_bit_q <= 1'b0;
      sticky_q    <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
      count_q     <= '0;
      z_out_q     <= '0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      z_stb_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_a_q      <= in_a_d;
      in_b_q      <= in_b_d;
      a_q         <= a_d;
      b_q         <= b_d;
      z_q         <= z_d;
      guard_q     <= guard_d;
      round_bit_q <= round_bit_d;
      sticky_q    <= sticky_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      count_q     <= count_d;
      z_out_q     <= z_out_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      z_stb_q     <= z_stb_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    in_a_d      = in_a_q;
    in_b_d      = in_b_q;
    a_d         = a_q;
    b_d         = b_q;
    z_d         = z_q;
    guard_d     = guard_q;
    round_bit_d = round_bit_q;
    sticky_d    = sticky_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    count_d     = count_q;
    z_out_d     = z_out_q;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    z_stb_d     = 1'b0;

    case (state_q)
      ST_GET_A: begin
        if (a_ack_q && input_a_stb) begin
          in_a_d  = input_a;
          state_d = ST_GET_B;
        end else begin
          a_ack_d = 1'b1;
        end
      end
      ST_GET_B: begin
        if (b_ack_q && input_b_stb) begin
          in_b_d  = input_b;
          state_d = ST_UNPACK;
        end else begin
          b_ack_d = 1'b1;
        end
      end
      ST_UNPACK: begin
        a_d.sign = in_a_q[63];
        a_d.exp  = EXP_W'(in_a_q[62:52]) - BIAS;
        a_d.man  = {1'b0, in_a_q[51:0]};
        b_d.sign = in_b_q[63];
        b_d.exp  = EXP_W'(in_b_q[62:52]) - BIAS;
        b_d.man  = {1'b0, in_b_q[51:0]};
        state_d  = ST_SPECIAL_CASES;
      end
      ST_SPECIAL_CASES: begin
        state_d = ST_PUT_Z;
        if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
          z_out_d = CANON_NAN;
        end else if (a_inf) begin
          z_out_d = signed_inf(z_sign);
        end else if (b_inf) begin
          z_out_d = signed_zero(z_sign);
        end else if (b_zero) begin
          z_out_d = signed_inf(z_sign);
        end else if (a_zero) begin
          z_out_d = signed_zero(z_sign);
        end else begin
          // Denormals carry no hidden bit and sit at the minimum normal exponent.
          if (a_q.exp == EXP_DENORM) a_d.exp = EXP_MIN_NORM;
          else                       a_d.man[52] = 1'b1;
          if (b_q.exp == EXP_DENORM) b_d.exp = EXP_MIN_NORM;
          else                       b_d.man[52] = 1'b1;
          state_d = ST_NORMALISE_A;
        end
      end
      ST_NORMALISE_A: begin
        if (!a_q.man[52]) begin
          a_d.man = a_q.man << 1;
          a_d.exp = a_q.exp - EXP_W'(1);
        end else begin
          state_d = ST_NORMALISE_B;
        end
      end
      ST_NORMALISE_B: begin
        if (!b_q.man[52]) begin
          b_d.man = b_q.man << 1;
          b_d.exp = b_q.exp - EXP_W'(1);
        end else begin
          state_d = ST_DIVIDE_0;
        end
      end
      ST_DIVIDE_0: begin
        z_d.sign = z_sign;
        z_d.exp  = a_q.exp - b_q.exp;
        z_d.man  = '0;
        rem_d    = REM_W'(a_q.man);
        quot_d   = '0;
        count_d  = '0;
        state_d  = ST_DIVIDE_1;
      end
      ST_DIVIDE_1: begin
        rem_d   = rem_next << 1;
        quot_d  = {quot_q[QUOT_W-2:0], rem_ge};
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(QUOT_W - 1)) state_d = ST_DIVIDE_2;
      end
      ST_DIVIDE_2: begin
        z_d.man     = quot_q[55:3];
        guard_d     = quot_q[2];
        round_bit_d = quot_q[1];
        sticky_d    = quot_q[0] | (rem_q != '0);
        state_d     = ST_NORMALISE_1;
      end
      ST_NORMALISE_1: begin
        if (!z_q.man[52]) begin
          z_d.man     = {z_q.man[51:0], guard_q};
          z_d.exp     = z_q.exp - EXP_W'(1);
          guard_d     = round_bit_q;
          round_bit_d = 1'b0;
        end else begin
          state_d = ST_NORMALISE_2;
        end
      end
      ST_NORMALISE_2: begin
        if (rp_need_shift) begin
          z_d         = rp_shifted;
          guard_d     = rp_guard;
          round_bit_d = rp_round_bit;
          sticky_d    = rp_sticky;
        end else begin
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        z_d     = rp_rounded;
        state_d = ST_PACK;
      end
      ST_PACK: begin
        z_out_d = rp_packed;
        state_d = ST_PUT_Z;
      end
      ST_PUT_Z: begin
        if (z_stb_q && output_z_ack) state_d = ST_GET_A;
        else                         z_stb_d = 1'b1;
      end
      default: state_d = ST_GET_A;
    endcase
  end

  assign input_a_ack  = a_ack_q;
  assign input_b_ack  = b_ack_q;
  assign output_z     = z_out_q;
  assign output_z_stb = z_stb_q;

endmodule

// File: doc/double_divider.md
Name: double_divider

Overview:
- IEEE-754 double-precision divider, z = a / b. It is the inverse-operation companion to the team's double multiplier.
- It uses the same three-channel stb/ack handshake: operand a, then operand b, then result z. This lets it drop into the same FPU datapaths and testbenches.
- Sequential restoring division produces one quotient bit per clock. The core has no pipelining and holds one operation in flight.

Parameters:
- None. Width is fixed at 64 bits, binary64.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high; clock clk
- input_a  input  64  dividend, binary64
- input_a_stb  input  1  dividend valid
- input_a_ack  output  1  dividend accepted
- input_b  input  64  divisor, binary64
- input_b_stb  input  1  divisor valid
- input_b_ack  output  1  divisor accepted
- output_z  output  64  quotient, binary64
- output_z_stb  output  1  quotient valid
- output_z_ack  input  1  quotient consumed

Behaviour:
- Reset values: input_a_ack=0, input_b_ack=0, output_z_stb=0, output_z=0, state=get_a. Reset overrides any state, including mid-division; the in-flight operation is discarded.
- Handshake: in get_a, ack is driven to 1. A transfer occurs on the edge where ack && stb. On that edge ack returns to 0 and the operand is latched. get_b works the same way. put_z drives stb=1 with z held stable; on the edge where stb && ack, stb goes to 0 and state returns to get_a. Back-to-back transfers have at least one idle cycle.
- States: get_a, get_b, unpack, special_cases, normalise_a, normalise_b, divide_0, divide_1, divide_2, normalise_1, normalise_2, round, pack, put_z (4-bit encoding).
- unpack: mantissa a_m/b_m = bits[51:0] into 53-bit registers. Exponent a_e/b_e = bits[62:52] − 1023 into 13-bit signed registers. Sign a_s/b_s = bit 63.
- special_cases are evaluated in priority order; each goes directly to put_z:
  - a or b is NaN → 0xFFF8000000000000.
  - a inf and b inf → 0xFFF8000000000000.
  - a inf → signed inf.
  - b inf → signed zero.
  - b zero and a zero → 0xFFF8000000000000.
  - b zero → signed inf.
  - a zero → signed zero.
  - Otherwise, denormal exponent −1023 becomes −1022; normal operands get the hidden bit m[52]=1.
- normalise_a/b: shift mantissa left and decrement exponent, one bit per cycle, until m[52]=1.
- divide_0:
  - z_s = a_s^b_s; z_e = a_e − b_e.
  - Remainder (54 bits) = a_m; quotient (56 bits) = 0; count = 0.
- divide_1, one cycle per iteration, 56 iterations:
  - If rem ≥ b_m: quotient bit = 1 and rem −= b_m.
  - Then rem <<= 1, shift the bit into the quotient LSB, count++.
  - Leave the state when count = 55 completes.
- divide_2: z_m = q[55:3], guard = q[2], round_bit = q[1], sticky = q[0] | (rem ≠ 0).
- normalise_1: while z_m[52]=0, shift left, z_m[0]=guard, guard=round_bit, round_bit=0, z_e−−. At most one shift for normalised inputs.
- normalise_2: while z_e < −1022, shift right, z_e++, guard=z_m[0], round_bit=guard, sticky |= round_bit. This produces gradual underflow.
- round: round-to-nearest-even. If guard && (round_bit|sticky|z_m[0]), then z_m++. If z_m was all-ones (53'h1FFFFFFFFFFFFF), z_e++ and the mantissa becomes 1<<52.
- pack:
  - exponent = z_e + 1023, mantissa = z_m[51:0], sign = z_s.
  - If z_e = −1022 and z_m[52] = 0, the exponent field is 0 (denormal).
  - If z_e > 1023, the result is signed inf. A result that rounds to zero is packed as signed zero.
- Latency: for normal operands with no quotient shift, output_z_stb rises 67 edges after the edge accepting b. Add 1 when a_m < b_m. Add 1 per leading-zero shift of denormal inputs or result. Add 1 per underflow shift. Special cases take 3 edges.

Decomposition:
- Shared package fpu_double_pkg:
  - Constants: BIAS=1023, EXP_MAX=1024, EXP_MIN_NORM=−1022, canonical NaN 0xFFF8000000000000, INF_EXP=2047.
  - State encoding.
  - Unpacked-double struct {sign, exp[12:0], man[52:0]}.
- One natural sub-module, double_round_pack: the shared normalise_2/round/pack post-processing, also reusable by the multiplier. The divide loop stays in the top module.

Test Plan:
- 0x4018000000000000 / 0x4000000000000000 (6/2) → 0x4008000000000000. Also check stb timing is exactly 67 edges after b accepted.
- 0x3FF0000000000000 / 0x4008000000000000 (1/3) → 0x3FD5555555555555, exercising rounding and the normalise_1 shift.
- Specials:
  - 1/0 → 0x7FF0000000000000.
  - 0/0 → 0xFFF8000000000000.
  - 1/inf → 0x0000000000000000.
  - NaN/1 → 0xFFF8000000000000.
- Boundaries:
  - 0x7FEFFFFFFFFFFFFF / 0x3FE0000000000000 → 0x7FF0000000000000 (overflow).
  - 0x0010000000000000 / 0x4000000000000000 → 0x0008000000000000 (denormal result).
  - 0x0000000000000001 / 0x3FE0000000000000 → 0x0000000000000002 (denormal input).
- Backpressure: hold output_z_ack=0 for 20 cycles. Required: output_z_stb stays 1, output_z stays stable, input_a_ack stays 0. On ack, stb drops next edge and input_a_ack rises the edge after.
- Reset mid-divide: assert rst for 1 cycle at iteration 30. Required next edge: acks=0, stb=0. The next operation (6/2) then completes correctly.
